// File: rtl/regfile_pkg.sv
// Shared encodings and defaults for the register-file operand stage.
// The optional feature macro REGFILE_BYPASS_EN is consumed by regfile_stage.
package regfile_pkg;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_R31  = 2'b10;
  localparam logic [1:0] DST_NONE = 2'b11;

  localparam logic [4:0]  REG_LINK         = 5'd31;
  localparam logic [31:0] RST_PAT_DEFAULT  = 32'hcccccccc;

endpackage

// File: rtl/regfile_array.sv
// 32-entry architectural register storage: NREAD combinational read ports,
// one synchronous write port, optional hard-wired zero register.
module regfile_array #(
  parameter int DATA_W  = 32,
  parameter int NREAD   = 2,
  parameter int ZERO_R0 = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_we,
  input  logic [4:0]              i_waddr,
  input  logic [DATA_W-1:0]       i_wdata,
  input  logic [NREAD*5-1:0]      i_raddr,
  output logic [NREAD*DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [32];
  logic              w_wr_ok;

  assign w_wr_ok = i_we && !((ZERO_R0 != 0) && (i_waddr == 5'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [4:0] w_addr;
    assign w_addr = i_raddr[k*5 +: 5];
    assign o_rdata[k*DATA_W +: DATA_W] =
      ((ZERO_R0 != 0) && (w_addr == 5'd0)) ? '0 : r_mem[w_addr];
  end

endmodule

// File: rtl/regfile_stage.sv
// Register-file stage: write-back/destination muxes, register array and
// stall/flush operand latches. Define REGFILE_BYPASS_EN for write-through forwarding.
module regfile_stage
  import regfile_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int          NREAD   = 2,
  parameter logic [31:0] RST_PAT = RST_PAT_DEFAULT,
  parameter int          ZERO_R0 = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             ir,
  input  logic [NREAD*5-1:0]      rd_addr,
  input  logic [DATA_W-1:0]       alu_res,
  input  logic [DATA_W-1:0]       mem_data,
  input  logic [DATA_W-1:0]       link_pc,
  input  logic [1:0]              wb_sel,
  input  logic [1:0]              dst_sel,
  input  logic                    reg_write,
  input  logic                    op_ld,
  input  logic                    op_clr,
  output logic [NREAD*DATA_W-1:0] rego,
  output logic                    op_valid
);

  localparam logic [DATA_W-1:0] W_RST = DATA_W'(RST_PAT);

  logic [DATA_W-1:0]       w_wb_data;
  logic [4:0]              w_dst_addr;
  logic                    w_wr_en;
  logic [NREAD*DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0]       w_lat_data [NREAD];
  logic [NREAD*DATA_W-1:0] r_rego;
  logic                    r_op_valid;
  logic                    w_unused_ir;

  // Opcode/funct/shamt fields belong to the decoder, not this stage.
  assign w_unused_ir = ^{ir[31:21], ir[10:0]};

  always_comb begin
    w_wb_data = alu_res;
    case (wb_sel)
      WB_MEM:  w_wb_data = mem_data;
      WB_LINK: w_wb_data = link_pc;
      default: w_wb_data = alu_res;
    endcase
  end

  always_comb begin
    w_dst_addr = 5'd0;
    case (dst_sel)
      DST_RT:  w_dst_addr = ir[20:16];
      DST_RD:  w_dst_addr = ir[15:11];
      DST_R31: w_dst_addr = REG_LINK;
      default: w_dst_addr = 5'd0;
    endcase
  end

  assign w_wr_en = reg_write && (dst_sel != DST_NONE) &&
                   !((ZERO_R0 != 0) && (w_dst_addr == 5'd0));

  regfile_array #(
    .DATA_W  (DATA_W),
    .NREAD   (NREAD),
    .ZERO_R0 (ZERO_R0)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr_en),
    .i_waddr (w_dst_addr),
    .i_wdata (w_wb_data),
    .i_raddr (rd_addr),
    .o_rdata (w_rdata)
  );

  // Without forwarding a same-edge write is invisible to the latch (old value).
  always_comb begin
    for (int k = 0; k < NREAD; k++) begin
      w_lat_data[k] = w_rdata[k*DATA_W +: DATA_W];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_en && (w_dst_addr == rd_addr[k*5 +: 5])) w_lat_data[k] = w_wb_data;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rego     <= {NREAD{W_RST}};
      r_op_valid <= 1'b0;
    end else if (op_clr) begin
      r_rego     <= {NREAD{W_RST}};
      r_op_valid <= 1'b0;
    end else if (op_ld) begin
      for (int k = 0; k < NREAD; k++) r_rego[k*DATA_W +: DATA_W] <= w_lat_data[k];
      r_op_valid <= 1'b1;
    end
  end

  assign rego     = r_rego;
  assign op_valid = r_op_valid;

endmodule

// File: tb/tb_regfile_stage.sv
// Randomised and directed bench for regfile_stage (NREAD=4) against an
// array-based reference model of the register file and operand latches.
module tb_regfile_stage;

  localparam int          DATA_W = 32;
  localparam int          NREAD  = 4;
  localparam logic [31:0] PAT    = 32'hcccccccc;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [31:0]             ir = '0;
  logic [NREAD*5-1:0]      rd_addr = '0;
  logic [DATA_W-1:0]       alu_res = '0, mem_data = '0, link_pc = '0;
  logic [1:0]              wb_sel = '0, dst_sel = 2'b11;
  logic                    reg_write = 1'b0, op_ld = 1'b0, op_clr = 1'b0;
  logic [NREAD*DATA_W-1:0] rego;
  logic                    op_valid;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_rf [32];
  logic [31:0] m_rego [NREAD];
  logic        m_valid;

  regfile_stage #(.DATA_W(DATA_W), .NREAD(NREAD), .RST_PAT(PAT), .ZERO_R0(1)) dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .rd_addr(rd_addr), .alu_res(alu_res),
    .mem_data(mem_data), .link_pc(link_pc), .wb_sel(wb_sel), .dst_sel(dst_sel),
    .reg_write(reg_write), .op_ld(op_ld), .op_clr(op_clr), .rego(rego), .op_valid(op_valid)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slice(input int k);
    return rego[k*DATA_W +: DATA_W];
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] rt, input logic [4:0] rd);
    return {11'h5a5, rt, rd, 11'h2b3};
  endfunction

  function automatic logic [19:0] addrs(input logic [4:0] a3, input logic [4:0] a2,
                                        input logic [4:0] a1, input logic [4:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    for (int k = 0; k < NREAD; k++) m_rego[k] = PAT;
    m_valid = 1'b0;
  endtask

  task automatic check_model(input string tag);
    for (int k = 0; k < NREAD; k++) check_val($sformatf("%s.rego%0d", tag, k), slice(k), m_rego[k]);
    check_val({tag, ".valid"}, {31'd0, op_valid}, {31'd0, m_valid});
  endtask

  // Apply one cycle of inputs, advance the model by the architectural rules,
  // then compare after the edge.
  task automatic step(input string tag, input logic [31:0] i_ir, input logic [19:0] i_ra,
                      input logic [31:0] i_alu, input logic [31:0] i_mem, input logic [31:0] i_link,
                      input logic [1:0] i_wb, input logic [1:0] i_dst,
                      input logic i_we, input logic i_ld, input logic i_clr);
    logic [31:0] wdata;
    int          waddr;
    bit          wr;
    logic [31:0] rv;
    ir = i_ir; rd_addr = i_ra; alu_res = i_alu; mem_data = i_mem; link_pc = i_link;
    wb_sel = i_wb; dst_sel = i_dst; reg_write = i_we; op_ld = i_ld; op_clr = i_clr;
    wdata = (i_wb == 2'd1) ? i_mem : (i_wb == 2'd2) ? i_link : i_alu;
    waddr = (i_dst == 2'd0) ? int'(i_ir[20:16]) : (i_dst == 2'd1) ? int'(i_ir[15:11]) : 31;
    wr    = i_we && (i_dst != 2'd3) && (waddr != 0);
    if (i_clr) begin
      for (int k = 0; k < NREAD; k++) m_rego[k] = PAT;
      m_valid = 1'b0;
    end else if (i_ld) begin
      for (int k = 0; k < NREAD; k++) begin
        int a;
        a  = int'(i_ra[k*5 +: 5]);
        rv = (a == 0) ? 32'd0 : m_rf[a];
`ifdef REGFILE_BYPASS_EN
        if (wr && a == waddr) rv = wdata;
`endif
        m_rego[k] = rv;
      end
      m_valid = 1'b1;
    end
    if (wr) m_rf[waddr] = wdata;
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic idle_ld(input string tag, input logic [19:0] i_ra);
    step(tag, '0, i_ra, '0, '0, '0, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    model_reset();
    #12;
    check_val("rst.rego0", slice(0), PAT);
    check_val("rst.rego3", slice(3), PAT);
    check_val("rst.valid", {31'd0, op_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    idle_ld("ld_zero", addrs(5'd0, 5'd0, 5'd0, 5'd3));
    check_val("ld_zero.p0", slice(0), 32'd0);
    check_val("ld_zero.p1", slice(1), 32'd0);
    check_val("ld_zero.valid", {31'd0, op_valid}, 32'd1);

    // rd path, ALU data
    step("wr_rd", mk_ir(5'd2, 5'd5), '0, 32'h12345678, 32'h0, 32'h0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0);
    idle_ld("rd_r5", addrs(5'd0, 5'd0, 5'd5, 5'd5));
    check_val("r5", slice(0), 32'h12345678);
    check_val("r5.dup", slice(1), 32'h12345678);
    // rt path, memory data
    step("wr_rt", mk_ir(5'd7, 5'd9), '0, 32'h1, 32'hdeadbeef, 32'h0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
    idle_ld("rd_r7", addrs(5'd0, 5'd0, 5'd0, 5'd7));
    check_val("r7", slice(0), 32'hdeadbeef);
    // link
    step("wr_link", mk_ir(5'd1, 5'd2), '0, 32'h1, 32'h2, 32'h00400010, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0);
    // r0 write dropped
    step("wr_r0", mk_ir(5'd0, 5'd3), '0, 32'hffffffff, 32'h0, 32'h0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    // reserved dst_sel: no write to rd=6
    step("wr_none", mk_ir(5'd4, 5'd6), '0, 32'h66, 32'h0, 32'h0, 2'd3, 2'd3, 1'b1, 1'b0, 1'b0);
    idle_ld("rd_link", addrs(5'd6, 5'd0, 5'd0, 5'd31));
    check_val("r31", slice(0), 32'h00400010);
    check_val("r0", slice(1), 32'd0);
    check_val("r6", slice(3), 32'd0);

    // Stall: latch r5, then write r5 with op_ld low
    idle_ld("stall_ld", addrs(5'd0, 5'd0, 5'd0, 5'd5));
    for (int i = 0; i < 3; i++)
      step("stall", mk_ir(5'd0, 5'd5), '0, 32'h1, 32'h0, 32'h0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0);
    check_val("stall.hold", slice(0), 32'h12345678);
    step("flush", '0, addrs(5'd1, 5'd2, 5'd3, 5'd5), '0, '0, '0, 2'd0, 2'd3, 1'b0, 1'b1, 1'b1);
    check_val("flush.p0", slice(0), PAT);
    check_val("flush.valid", {31'd0, op_valid}, 32'd0);

    // Same-edge write and load of r9
    step("hz_a", mk_ir(5'd0, 5'd9), '0, 32'hA, '0, '0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0);
    step("hz_b", mk_ir(5'd0, 5'd9), addrs(5'd0, 5'd0, 5'd0, 5'd9), 32'hB, '0, '0, 2'd0, 2'd1,
         1'b1, 1'b1, 1'b0);
`ifdef REGFILE_BYPASS_EN
    check_val("hz.same", slice(0), 32'hB);
`else
    check_val("hz.same", slice(0), 32'hA);
`endif
    idle_ld("hz_next", addrs(5'd0, 5'd0, 5'd0, 5'd9));
    check_val("hz.next", slice(0), 32'hB);

    // Four ports
    for (int i = 1; i <= 4; i++)
      step("pre", mk_ir(5'(i), 5'd0), '0, 32'(i), '0, '0, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0);
    idle_ld("p4", addrs(5'd4, 5'd3, 5'd2, 5'd1));
    check_val("p4.0", slice(0), 32'd1);
    check_val("p4.3", slice(3), 32'd4);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step("rnd", $urandom, 20'($urandom), $urandom, $urandom, $urandom,
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    end
    for (int b = 0; b < 32; b += 4)
      idle_ld("dump", addrs(5'(b + 3), 5'(b + 2), 5'(b + 1), 5'(b)));

    // Async reset in the middle of a write cycle
    ir = mk_ir(5'd12, 5'd12); alu_res = 32'h77; wb_sel = 2'd0; dst_sel = 2'd0;
    reg_write = 1'b1; op_ld = 1'b1; op_clr = 1'b0; rd_addr = addrs(5'd1, 5'd2, 5'd3, 5'd4);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("arst.p0", slice(0), PAT);
    check_val("arst.p2", slice(2), PAT);
    check_val("arst.valid", {31'd0, op_valid}, 32'd0);
    @(posedge clk); #1;
    check_model("arst.edge");
    rst_n = 1'b1;
    for (int b = 0; b < 32; b += 4)
      idle_ld("post_rst", addrs(5'(b + 3), 5'(b + 2), 5'(b + 1), 5'(b)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_stage.md
Name: regfile_stage

Overview:
- Parametrised successor of the multi-cycle register-file stage: a 32-entry architectural register file plus write-back source mux, destination mux, and registered operand latches.
- Provides NREAD read ports, a link (r31) write path, and stall/flush control of the operand latches.
- Sits between the IR/decode and the ALU operand muxes of the multi-cycle MIPS datapath.
- Write-back data arrives from the ALU result, memory data, or the link PC.

Parameters:
- DATA_W, 32, register and operand width; must be >= 32.
- NREAD, 2, number of read ports (2..4). Ports 0/1 carry rs/rt.
- RST_PAT, 32'hcccccccc, operand-latch reset and flush value; truncated or zero-extended to DATA_W.
- ZERO_R0, 1, 1 = r0 reads 0 and ignores writes.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ir  in  32  instruction register; rt=ir[20:16], rd=ir[15:11].
- rd_addr  in  NREAD*5  read addresses, port k at [5k+4:5k].
- alu_res  in  DATA_W  ALU result.
- mem_data  in  DATA_W  memory read data.
- link_pc  in  DATA_W  return address for jal/jalr.
- wb_sel  in  2  00 alu_res, 01 mem_data, 10 link_pc, 11 reserved (treated as 00).
- dst_sel  in  2  00 rt, 01 rd, 10 r31, 11 reserved (no write).
- reg_write  in  1  write enable.
- op_ld  in  1  load the operand latches this cycle.
- op_clr  in  1  flush the operand latches.
- rego  out  NREAD*DATA_W  latched operands, port k at [DATA_W*(k+1)-1:DATA_W*k].
- op_valid  out  1  latches hold data loaded since the last reset or flush.

Behaviour:
- Reset (async, rst_n low):
  - every rego slice = RST_PAT; op_valid=0.
  - Register array is cleared to 0, so all 32 entries read 0 after reset.
- Write:
  - On posedge clk with reg_write=1 and dst_sel!=11, write wb_sel-mux data to the dst_sel address.
  - Destination r0 with ZERO_R0=1: write is dropped.
- Read: combinational array read per port. Address 0 with ZERO_R0=1 returns 0 regardless of array contents.
- Operand latch, evaluated at posedge, in priority order:
  - op_clr=1: all slices = RST_PAT, op_valid=0. op_clr wins over op_ld.
  - else op_ld=1: slice k = read value of rd_addr[k]; op_valid=1.
  - else: hold, including op_valid.
- Latency: rd_addr/op_ld at edge N gives rego valid after edge N, usable in cycle N+1, matching the single-register operand stage.
- Same-edge write and load to the same address: see the optional feature.
- Multiple ports reading the same address all get the same value.
- Reset asserted mid-operation: immediate async clear. Any write at that edge is lost.
- No X propagation: reserved encodings are defined as above.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If reg_write and the decoded destination (non-zero when ZERO_R0=1) equals rd_addr[k] on a loading edge, slice k latches the write data (new value).
- Not defined: slice k latches the pre-write array value (old value); the controller must insert a cycle.
- Defined or not, the array contents after the edge are identical.

Decomposition:
- Package regfile_pkg holds:
  - WB_ALU/WB_MEM/WB_LINK encodings;
  - DST_RT/DST_RD/DST_R31/DST_NONE encodings;
  - REG_LINK=5'd31;
  - default RST_PAT constant.
- Natural sub-module: regfile_array, the 32xDATA_W storage with NREAD async read ports, one sync write port, and ZERO_R0 handling.
- regfile_stage adds the muxes, optional bypass, and operand latches.

Test Plan:
- Reset check: hold rst_n=0 -> rego slices = 32'hcccccccc, op_valid=0. Release; op_ld with rd_addr={5'd3,5'd0} -> rego={0,0}, op_valid=1.
- Write/read, both dst_sel paths:
  - ir rd=5 (dst_sel=01), wb_sel=00, alu_res=32'h1234_5678, reg_write=1 -> then op_ld rd_addr[0]=5 -> rego[0]=32'h12345678.
  - Repeat with rt=7 (dst_sel=00), wb_sel=01, mem_data=32'hdeadbeef -> reading 7 returns 32'hdeadbeef.
- Link and r0:
  - dst_sel=10, wb_sel=10, link_pc=32'h0040_0010 -> r31 reads 32'h00400010.
  - Write 32'hffffffff to r0 -> r0 reads 0.
- Stall and flush:
  - load r5 then op_ld=0 for 3 cycles while writing r5=32'h1 -> rego[0] stays 32'h12345678.
  - op_clr=1 with op_ld=1 -> RST_PAT, op_valid=0.
- Same-edge hazard: r9=32'hA, then same edge writes r9=32'hB and op_ld reads 9 -> rego=32'hB with REGFILE_BYPASS_EN, 32'hA without; next load gives 32'hB in both builds.
- NREAD=4 build: ports read r1..r4 preloaded with 1..4 -> rego={4,3,2,1}. Async reset mid-write returns RST_PAT immediately, before the next clock edge.
